// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard/stall sequencer: load-use, branch flush, dmem wait, perf counters
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rt,
    input  logic             mem_pcSrc,
    input  logic             mem_MemRead,
    input  logic             mem_MemWrite,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic mem_acc;
    logic load_use;
    logic mem_stall;

    assign mem_acc  = mem_MemRead | mem_MemWrite;
    assign load_use = ex_MemRead && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        mem_stall   = 1'b0;
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_en     = 1'b0;
            idex_flush  = 1'b1;
            exmem_en    = 1'b0;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
            state_d     = ST_RUN;
            wait_cnt_d  = '0;
            timeout_d   = 1'b0;
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (state_q == ST_RUN) begin
                if (mem_acc && !dmem_ready) begin
                    mem_stall  = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end else begin
                // EX/MEM is frozen while waiting, so the access is assumed still pending
                if (dmem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else begin
                    mem_stall  = 1'b1;
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            if (mem_stall) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_en    = 1'b0;
                memwb_flush = 1'b1;
            end else if (mem_pcSrc) begin
                // the ID instruction is on the wrong path, so a load-use on it is moot
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                if (!(&flush_cnt_q)) begin
                    flush_cnt_d = flush_cnt_q + CNT_W'(1);
                end
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end

            if (!pc_en && !(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_timeout = timeout_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule
